// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcode constants, the ALU
// operation encoding seen by execute, the decode FSM state encoding and the
// bundle of decoded control bits that is registered together.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_SR      = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_OPREAD = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Control bits produced by decode; all-zero is the reset/NOP value
    // (alu_op all-zero is ADD).
    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    branch;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    illegal;
    } ctrl_t;

    // Maps funct3 plus the funct7[5] "alternate" bit to an ALU operation.
    // The caller decides whether alt is meaningful for the opcode.
    function automatic alu_op_e funct3_to_alu(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of the decode stage's handshake and data signals.
//   master : upstream side (fetch pulses IF_kick_up and supplies the
//            instruction word; the register file returns read data) and
//            consumer of the decoded results.
//   slave  : the decode stage itself.
// Signal summary:
//   IF_kick_up, inst_mem_read_data        fetch -> decode
//   reg_read_addr1/2, reg_read_data1/2    decode <-> register file
//   rs1_data, rs2_data, rd_addr, imme,
//   Controller_branch, alu_op, alu_src,
//   mem_read, mem_write, reg_write,
//   illegal_inst, ID_kick_up              decode -> execute / fetch
interface decode_stage_if;
    import decode_pkg::*;

    logic        IF_kick_up;
    logic [31:0] inst_mem_read_data;
    logic [31:0] reg_read_data1;
    logic [31:0] reg_read_data2;
    logic [4:0]  reg_read_addr1;
    logic [4:0]  reg_read_addr2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic [31:0] imme;
    logic        Controller_branch;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal_inst;
    logic        ID_kick_up;

    modport master (
        output IF_kick_up, inst_mem_read_data, reg_read_data1, reg_read_data2,
        input  reg_read_addr1, reg_read_addr2, rs1_data, rs2_data, rd_addr, imme,
               Controller_branch, alu_op, alu_src, mem_read, mem_write,
               reg_write, illegal_inst, ID_kick_up
    );

    modport slave (
        input  IF_kick_up, inst_mem_read_data, reg_read_data1, reg_read_data2,
        output reg_read_addr1, reg_read_addr2, rs1_data, rs2_data, rd_addr, imme,
               Controller_branch, alu_op, alu_src, mem_read, mem_write,
               reg_write, illegal_inst, ID_kick_up
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator for the supported RV32I formats.
// Ports:
//   inst : 32-bit instruction word
//   imme : 32-bit sign-extended immediate (0 for formats without one)
// Branch immediates are produced as the byte offset divided by two, i.e. the
// raw 12-bit B-field without the implicit zero LSB.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imme
);

    always_comb begin
        imme = '0;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD: imme = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:            imme = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:           imme = {{20{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8]};
            OPC_LUI:              imme = {inst[31:12], 12'b0};
            default:              imme = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode step of the multi-cycle RV32I core.
// Captures the fetched word on IF_kick_up, decodes it, reads both source
// registers and pulses ID_kick_up once everything downstream needs is valid.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : decode_stage_if slave modport (fetch handshake, register-file
//           read port, decoded outputs towards execute/fetch)
module decode_stage
    import decode_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] imme_q, imme_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rs1_data_q, rs1_data_d;
    logic [31:0] rs2_data_q, rs2_data_d;
    logic        id_kick_up;

    ctrl_t       dec_ctrl;
    logic [31:0] gen_imme;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;

    assign opcode    = inst_q[6:0];
    assign funct3    = inst_q[14:12];
    assign funct7_b5 = inst_q[30];

    imm_gen u_imm_gen (
        .inst (inst_q),
        .imme (gen_imme)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a fixed walk through the four steps; a new kick is
    // only accepted while idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.IF_kick_up) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_OPREAD;
            ST_OPREAD: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control decode of the latched instruction. Unsupported encodings fall
    // through as a NOP with only the illegal flag set.
    always_comb begin
        dec_ctrl        = '0;
        dec_ctrl.alu_op = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = funct3_to_alu(funct3, funct7_b5);
            end
            OPC_OP_IMM: begin
                // funct7[5] only distinguishes SRAI from SRLI; for the other
                // immediates it is just an immediate bit.
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = funct3_to_alu(funct3, (funct3 == F3_SR) && funct7_b5);
            end
            OPC_LOAD: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OPC_STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OPC_BRANCH: begin
                // Only BEQ is supported; SUB lets execute use Zero as "equal".
                if (funct3 == F3_BEQ) begin
                    dec_ctrl.branch = 1'b1;
                    dec_ctrl.alu_op = ALU_SUB;
                end else begin
                    dec_ctrl.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_PASSB;
            end
            default: dec_ctrl.illegal = 1'b1;
        endcase
    end

    // FSM outputs and per-state register loads; everything not loaded in
    // the current state holds its previous value.
    always_comb begin
        inst_d     = inst_q;
        ctrl_d     = ctrl_q;
        imme_d     = imme_q;
        rd_addr_d  = rd_addr_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        id_kick_up = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.IF_kick_up) inst_d = bus.inst_mem_read_data;
            end
            ST_DECODE: begin
                ctrl_d    = dec_ctrl;
                imme_d    = dec_ctrl.illegal ? 32'd0 : gen_imme;
                rd_addr_d = inst_q[11:7];
            end
            ST_OPREAD: begin
                rs1_data_d = bus.reg_read_data1;
                rs2_data_d = bus.reg_read_data2;
            end
            ST_DONE: begin
                id_kick_up = 1'b1;
            end
            default: id_kick_up = 1'b0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_q     <= '0;
            ctrl_q     <= '0;
            imme_q     <= '0;
            rd_addr_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            inst_q     <= inst_d;
            ctrl_q     <= ctrl_d;
            imme_q     <= imme_d;
            rd_addr_q  <= rd_addr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    // Source addresses come straight from the latched word so the register
    // file has the whole OPREAD cycle to respond.
    assign bus.reg_read_addr1    = inst_q[19:15];
    assign bus.reg_read_addr2    = inst_q[24:20];
    assign bus.rs1_data          = rs1_data_q;
    assign bus.rs2_data          = rs2_data_q;
    assign bus.rd_addr           = rd_addr_q;
    assign bus.imme              = imme_q;
    assign bus.Controller_branch = ctrl_q.branch;
    assign bus.alu_op            = ctrl_q.alu_op;
    assign bus.alu_src           = ctrl_q.alu_src;
    assign bus.mem_read          = ctrl_q.mem_read;
    assign bus.mem_write         = ctrl_q.mem_write;
    assign bus.reg_write         = ctrl_q.reg_write;
    assign bus.illegal_inst      = ctrl_q.illegal;
    assign bus.ID_kick_up        = id_kick_up;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a table of directed instructions with
// hand-computed decode results, plus sequences for reset and busy behaviour.
module tb_decode_stage;
    import decode_pkg::*;

    logic clk;
    logic reset;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imme;
        logic [4:0]  rd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        illegal;
    } vec_t;

    localparam int NUM_VECS = 10;
    vec_t vecs[NUM_VECS];

    int checks = 0;
    int errors = 0;

    // Compares one observed value against its expectation.
    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Kicks one instruction in and waits (bounded) for ID_kick_up; returns
    // how many negedges after the sampling edge the pulse appeared.
    task automatic apply_stimulus(input logic [31:0] inst, input logic [31:0] rd1,
                                  input logic [31:0] rd2, output int cycles);
        @(negedge clk);
        bus.inst_mem_read_data = inst;
        bus.reg_read_data1     = rd1;
        bus.reg_read_data2     = rd2;
        bus.IF_kick_up         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.IF_kick_up = 1'b0;
        cycles = 1;
        while (!bus.ID_kick_up && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " imme"}, bus.imme, 32'd0);
        check_output({tag, " rd_addr"}, 32'(bus.rd_addr), 32'd0);
        check_output({tag, " read addrs"}, 32'({bus.reg_read_addr1, bus.reg_read_addr2}), 32'd0);
        check_output({tag, " alu_op"}, 32'(bus.alu_op), 32'd0);
        check_output({tag, " ctrl"}, 32'({bus.alu_src, bus.Controller_branch, bus.mem_read,
                                          bus.mem_write, bus.reg_write, bus.illegal_inst}), 32'd0);
        check_output({tag, " rs1_data"}, bus.rs1_data, 32'd0);
        check_output({tag, " rs2_data"}, bus.rs2_data, 32'd0);
        check_output({tag, " ID_kick_up"}, 32'(bus.ID_kick_up), 32'd0);
    endtask

    initial begin
        int cycles;
        int kicks;
        int first_kick;

        //            name      inst          rd1           rd2           imme          rd  ra1 ra2 alu src br mr mw rw ill
        vecs[0] = '{"addi",    32'h00500093, 32'h11111111, 32'h22222222, 32'h00000005, 1,  0,  5,  0,  1, 0, 0, 0, 1, 0};
        vecs[1] = '{"beq",     32'hFE208CE3, 32'h00000007, 32'h00000007, 32'hFFFFFFFC, 25, 1,  2,  1,  0, 1, 0, 0, 0, 0};
        vecs[2] = '{"sw",      32'h0020A623, 32'h00001000, 32'hDEADBEEF, 32'h0000000C, 12, 1,  2,  0,  1, 0, 0, 1, 0, 0};
        vecs[3] = '{"lui",     32'h123452B7, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345000, 5,  8,  3,  10, 1, 0, 0, 0, 1, 0};
        vecs[4] = '{"ones",    32'hFFFFFFFF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h00000000, 31, 31, 31, 0,  0, 0, 0, 0, 0, 1};
        vecs[5] = '{"sub",     32'h402081B3, 32'h00000064, 32'h0000000A, 32'h00000000, 3,  1,  2,  1,  0, 0, 0, 0, 1, 0};
        vecs[6] = '{"srai",    32'h4030D213, 32'h80000000, 32'h00000003, 32'h00000403, 4,  1,  3,  7,  1, 0, 0, 0, 1, 0};
        vecs[7] = '{"addi_b30",32'h40000093, 32'h00000000, 32'h00000000, 32'h00000400, 1,  0,  0,  0,  1, 0, 0, 0, 1, 0};
        vecs[8] = '{"lw",      32'hFFC12303, 32'h00002000, 32'h00000077, 32'hFFFFFFFC, 6,  2,  28, 0,  1, 0, 1, 0, 1, 0};
        vecs[9] = '{"bne",     32'hFE209CE3, 32'h00000001, 32'h00000002, 32'h00000000, 25, 1,  2,  0,  0, 0, 0, 0, 0, 1};

        bus.IF_kick_up         = 1'b0;
        bus.inst_mem_read_data = '0;
        bus.reg_read_data1     = '0;
        bus.reg_read_data2     = '0;
        reset                  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("post-reset");

        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i].inst, vecs[i].rd1, vecs[i].rd2, cycles);
            check_output({vecs[i].name, " kick latency"}, 32'(cycles), 32'd3);
            check_output({vecs[i].name, " imme"}, bus.imme, vecs[i].imme);
            check_output({vecs[i].name, " rd_addr"}, 32'(bus.rd_addr), 32'(vecs[i].rd));
            check_output({vecs[i].name, " ra1"}, 32'(bus.reg_read_addr1), 32'(vecs[i].ra1));
            check_output({vecs[i].name, " ra2"}, 32'(bus.reg_read_addr2), 32'(vecs[i].ra2));
            check_output({vecs[i].name, " alu_op"}, 32'(bus.alu_op), 32'(vecs[i].alu_op));
            check_output({vecs[i].name, " ctrl"},
                         32'({bus.alu_src, bus.Controller_branch, bus.mem_read,
                              bus.mem_write, bus.reg_write, bus.illegal_inst}),
                         32'({vecs[i].alu_src, vecs[i].branch, vecs[i].mem_read,
                              vecs[i].mem_write, vecs[i].reg_write, vecs[i].illegal}));
            check_output({vecs[i].name, " rs1_data"}, bus.rs1_data, vecs[i].rd1);
            check_output({vecs[i].name, " rs2_data"}, bus.rs2_data, vecs[i].rd2);
            @(negedge clk);
            check_output({vecs[i].name, " kick one cycle"}, 32'(bus.ID_kick_up), 32'd0);
        end

        // Load nonzero outputs, then abort a second instruction in OPREAD.
        apply_stimulus(32'h00500093, 32'h11111111, 32'h22222222, cycles);
        check_output("pre-abort kick latency", 32'(cycles), 32'd3);
        @(negedge clk);
        bus.inst_mem_read_data = 32'h123452B7;
        bus.IF_kick_up         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.IF_kick_up = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset = 1'b1;
        kicks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.ID_kick_up) kicks++;
        end
        check_output("abort no kick", 32'(kicks), 32'd0);
        check_output("abort rd_addr held 0", 32'(bus.rd_addr), 32'd0);

        // A second kick while in DECODE must be ignored.
        @(negedge clk);
        bus.inst_mem_read_data = 32'h00500093;
        bus.reg_read_data1     = 32'h0000AAAA;
        bus.reg_read_data2     = 32'h0000BBBB;
        bus.IF_kick_up         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.inst_mem_read_data = 32'h123452B7;
        bus.IF_kick_up         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.IF_kick_up = 1'b0;
        kicks      = 0;
        first_kick = 0;
        for (int c = 2; c < 10; c++) begin
            if (bus.ID_kick_up) begin
                kicks++;
                if (first_kick == 0) first_kick = c;
            end
            @(negedge clk);
        end
        check_output("busy kick count", 32'(kicks), 32'd1);
        check_output("busy kick latency", 32'(first_kick), 32'd3);
        check_output("busy imme", bus.imme, 32'h00000005);
        check_output("busy rd_addr", 32'(bus.rd_addr), 32'd1);
        check_output("busy alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
        check_output("busy ra2", 32'(bus.reg_read_addr2), 32'd5);
        check_output("busy rs1_data", bus.rs1_data, 32'h0000AAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
